// File: rtl/normalize_pkg.sv
// Shared types and sizing for the left-shift normalizer.
// Widths are fixed: a 32-bit work register and a 16-bit result.
package normalize_pkg;

  localparam int WIDTH = 32;
  localparam int OUT_W = 16;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_left_register_32bit.sv
// 32-bit loadable left-shift register, zero fill at bit 0.
// Synchronous reset; load wins over shift.
module shift_left_register_32bit
  import normalize_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shiftleften,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= data_in;
    end else if (shiftleften) begin
      r_q <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/normalize_shift_left_32bit.sv
// Left-shift normalizer: shifts until the leading one reaches bit 31,
// then reports the upper half, the shift count and a zero flag.
module normalize_shift_left_32bit
  import normalize_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] data_out,
  output logic [CNT_W-1:0] shift_count,
  output logic             zero
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [OUT_W-1:0] r_data_out;
  logic [CNT_W-1:0] r_shift_count;
  logic             r_zero;

  logic [WIDTH-1:0] w_q;
  logic             w_load;
  logic             w_shift;
  logic             w_q_zero;
  logic             w_q_norm;

  assign w_q_zero = (w_q == '0);
  assign w_q_norm = w_q[WIDTH-1];
  assign w_load   = (r_state == IDLE) && start;
  assign w_shift  = (r_state == SHIFT) && !w_q_zero && !w_q_norm;

  shift_left_register_32bit u_sreg (
    .clk         (clk),
    .rst         (rst),
    .load        (w_load),
    .shiftleften (w_shift),
    .data_in     (data_in),
    .q           (w_q)
  );

  // Results latch on the edge into DONE so they are valid with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_data_out    <= '0;
      r_shift_count <= '0;
      r_zero        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (w_q_zero || w_q_norm) begin
            r_state       <= DONE;
            r_done        <= 1'b1;
            r_data_out    <= w_q[WIDTH-1 -: OUT_W];
            r_shift_count <= r_cnt;
            r_zero        <= w_q_zero;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign data_out    = r_data_out;
  assign shift_count = r_shift_count;
  assign zero        = r_zero;

endmodule

// File: tb/tb_normalize_shift_left_32bit.sv
// Self-checking bench for the left-shift normalizer.
// Directed cases plus random values against an arithmetic reference.
module tb_normalize_shift_left_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [15:0] data_out;
  logic [4:0]  shift_count;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  normalize_shift_left_32bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .shift_count (shift_count),
    .zero        (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: position of the leading one gives the shift distance.
  task automatic model(input logic [31:0] x, output int s,
                       output logic [15:0] o, output logic z);
    int k;
    logic [31:0] t;
    k = -1;
    for (int i = 0; i < 32; i++)
      if (x[i]) k = i;
    z = (x == 0);
    s = z ? 0 : 31 - k;
    t = x << s;
    o = t[31:16];
  endtask

  // Start at a negedge in IDLE; optionally inject a start mid-flight.
  task automatic run(input string tag, input logic [31:0] x,
                     input int inject_at);
    int s, lat;
    logic [15:0] eo;
    logic ez;
    model(x, s, eo, ez);
    start = 1'b1;
    data_in = x;
    @(posedge clk);
    #1;
    start = 1'b0;
    data_in = $urandom;
    @(negedge clk);
    lat = 0;
    while (!done && lat < 40) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      lat++;
      if (lat == inject_at) begin
        start = 1'b1;
        data_in = 32'hFFFF_FFFF;
      end else if (lat == inject_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(s + 1));
    check({tag, "_dbusy"}, 32'(busy), 32'd1);
    check({tag, "_out"}, 32'(data_out), 32'(eo));
    check({tag, "_cnt"}, 32'(shift_count), 32'(s));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(data_out), 32'(eo));
  endtask

  initial begin
    logic seen;
    logic [31:0] r;
    rst = 1'b1;
    start = 1'b1;
    data_in = 32'h8000_0000;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(data_out), 32'd0);
    check("rst_cnt", 32'(shift_count), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run("msb", 32'h8000_0000, -1);
    run("mid", 32'h0000_8000, -1);
    run("f012", 32'h00F0_1234, -1);
    run("lsb", 32'h0000_0001, -1);
    run("zero", 32'h0000_0000, -1);
    run("ign", 32'h0000_8000, 4);
    run("ones", 32'hFFFF_FFFF, -1);

    for (int i = 0; i < 24; i++) begin
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) r = 32'h0;
      run("rnd", r, -1);
    end

    // Reset in the middle of a long shift sequence.
    start = 1'b1;
    data_in = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_out", 32'(data_out), 32'd0);
    check("mrst_cnt", 32'(shift_count), 32'd0);
    check("mrst_zero", 32'(zero), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done | busy;
    end
    check("mrst_quiet", 32'(seen), 32'd0);
    run("after", 32'h0000_0001, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
